mdio_xact_gen: RTL and testbench
================================

MDIO_XACT_GEN -- requirements
Module: mdio_xact_gen

Interface
REQ-001 Parameter DIV, default 2, MDC half-period in CLK cycles (legal >= 1).
REQ-002 Parameter PRE_LEN, default 32, preamble length in MDC periods (legal 1..63).
REQ-003 CLK  input  1  single block clock, all logic on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 MDIO_START  input  1  request; sampled only in IDLE.
REQ-006 T_DATA  input  32  frame word: [31:30] ST, [29:28] OP, [27:23] PHYAD/PRTAD, [22:18] REGAD/DEVAD, [17:16] TA, [15:0] data.
REQ-007 MDIO_IN  input  1  serial data from PHY.
REQ-008 MDC  output  1  management clock.
REQ-009 MDIO_OUT  output  1  serial data to PHY.
REQ-010 MDIO_OE  output  1  pad output enable.
REQ-011 RD_DATA  output  16  last read word.
REQ-012 DATA_RDY  output  1  one-cycle pulse, read data valid.
REQ-013 DONE  output  1  one-cycle pulse, any frame complete.
REQ-014 BUSY  output  1  frame in progress.
REQ-015 TA_ERR  output  1  read turnaround error, valid with DONE, held until next capture.
REQ-016 OP_ERR  output  1  one-cycle pulse, illegal ST/OP rejected.

Function
REQ-017 FSM states: IDLE, PRE, HDR (ST..REGAD, 14 bits), TA (2 bits), DATA (16 bits), FIN.
REQ-018 IDLE with MDIO_START=1 at cycle 0: T_DATA captured; later T_DATA/MDIO_START changes ignored until IDLE re-entered.
REQ-019 Legal: ST=01 with OP 01 (write) or 10 (read); ST=00 (Clause 45) with OP 00 (address), 01 (write), 11 (read), 10 (read-inc); all else -> OP_ERR at cycle 1, BUSY stays 0, no MDC activity.
REQ-020 Legal capture: BUSY=1 from cycle 1; bit k of the frame (k=0 first) driven on MDIO_OUT from cycle 1+2*DIV*k, MDC low at that cycle, rising at 1+2*DIV*k+DIV.
REQ-021 MDC held 0 outside PRE/HDR/TA/DATA; MDIO_OUT=0 and MDIO_OE=0 in IDLE.
REQ-022 PRE drives 1s; HDR, TA, DATA drive T_DATA bits MSB first.
REQ-023 Reads (C22 OP 10, C45 OP 11/10): MDIO_OE=0 from first TA bit through end of DATA; writes/address: MDIO_OE=1 for whole frame.
REQ-024 Reads: MDIO_IN sampled on each MDC rising edge; second TA sample must be 0, else TA_ERR=1; 16 DATA samples shifted MSB first.
REQ-025 Frame of N bits: FIN at cycle 1+2*DIV*N; DONE pulses, BUSY falls, RD_DATA updated and DATA_RDY pulses (reads only) in that cycle.
REQ-026 Back-to-back: MDIO_START sampled again in cycle after FIN; minimum idle one CLK.
REQ-027 Counters sized for max PRE_LEN; no wrap within a frame.

Reset
REQ-028 RESET=1 forces IDLE; MDC, MDIO_OUT, MDIO_OE, DATA_RDY, DONE, BUSY, TA_ERR, OP_ERR, RD_DATA = 0 next cycle.
REQ-029 Reset mid-frame aborts silently: no DONE, no DATA_RDY; RESET has priority over MDIO_START.

Configuration
REQ-030 MDIO_PREAMBLE_EN defined: PRE state emits PRE_LEN ones, N=PRE_LEN+32.
REQ-031 MDIO_PREAMBLE_EN undefined: PRE skipped, PRE_LEN ignored, N=32.

Structure
REQ-032 Package mdio_pkg: FSM state encoding, ST/OP constants, T_DATA field bit positions.
REQ-033 Sub-module mdio_clk_div: generates MDC plus rise/fall strobes from DIV, enabled only while framing.

Verification (DIV=2, PRE_LEN=32, MDIO_PREAMBLE_EN defined)
REQ-034 Write T_DATA=0x508ABEEF -> 32 ones then 0x508ABEEF serial, OE=1 all 64 periods, DONE at cycle 257, DATA_RDY=0.
REQ-035 C22 read T_DATA=0x60880000, PHY drives TA 0 then 0x1234 -> RD_DATA=0x1234, DATA_RDY+DONE at cycle 257, TA_ERR=0, OE=0 last 18 periods.
REQ-036 Same read, MDIO_IN held 1 -> RD_DATA=0xFFFF, TA_ERR=1.
REQ-037 T_DATA=0x70000000 -> OP_ERR pulse cycle 1, BUSY=0, MDC=0 throughout.
REQ-038 C45 read T_DATA=0x30880000 with PHY data 0xA5A5 -> RD_DATA=0xA5A5; START re-pulsed with 0x508ABEEF at cycle 50 ignored.
REQ-039 RESET at cycle 100 of a write -> all outputs 0 at cycle 101, no DONE; new START after release runs full frame.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO transaction generator: FSM encoding,
// ST/OP codes, frame-word field positions and frame section lengths.
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4,
    S_FIN  = 3'd5
  } state_e;

  localparam logic [1:0] ST_C22      = 2'b01;
  localparam logic [1:0] ST_C45      = 2'b00;
  localparam logic [1:0] OP_C22_WR   = 2'b01;
  localparam logic [1:0] OP_C22_RD   = 2'b10;
  localparam logic [1:0] OP_C45_ADDR = 2'b00;
  localparam logic [1:0] OP_C45_WR   = 2'b01;

  // Field positions within the 32-bit frame word.
  localparam int ST_LSB    = 30;
  localparam int OP_LSB    = 28;
  localparam int DATA_BITS = 16;

  localparam int HDR_BITS    = 14;
  localparam int TA_BITS     = 2;
  localparam int MAX_PRE_LEN = 63;
  localparam int CNT_W       = $clog2(MAX_PRE_LEN + 1);

  typedef struct packed {
    logic legal;
    logic read;
  } op_class_t;

  function automatic op_class_t classify(input logic [1:0] st, input logic [1:0] op);
    op_class_t c;
    c = '{legal: 1'b0, read: 1'b0};
    if (st == ST_C22) begin
      c.legal = (op == OP_C22_WR) || (op == OP_C22_RD);
      c.read  = (op == OP_C22_RD);
    end else if (st == ST_C45) begin
      c.legal = 1'b1;
      c.read  = (op != OP_C45_ADDR) && (op != OP_C45_WR);
    end
    return c;
  endfunction

endpackage

// File: rtl/mdio_clk_div.sv
// MDC generator: DIV CLK cycles per half-period, plus strobes flagging the
// CLK edge on which MDC rises or falls. Held low and phase-aligned when idle.
module mdio_clk_div #(
  parameter int DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_mdc,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_mdc;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_mdc <= ~r_mdc;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_mdc      = r_mdc;
  assign o_rise_stb = i_en & w_wrap & ~r_mdc;
  assign o_fall_stb = i_en & w_wrap & r_mdc;

endmodule

// File: rtl/mdio_xact_gen.sv
// MDIO (Clause 22/45) frame generator. Define MDIO_PREAMBLE_EN to prepend
// PRE_LEN preamble ones to every frame; otherwise frames start at ST.
module mdio_xact_gen
  import mdio_pkg::*;
#(
  parameter int DIV     = 2,
  parameter int PRE_LEN = 32
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mdio_start,
  input  logic [31:0] i_t_data,
  input  logic        i_mdio_in,
  output logic        o_mdc,
  output logic        o_mdio_out,
  output logic        o_mdio_oe,
  output logic [15:0] o_rd_data,
  output logic        o_data_rdy,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_ta_err,
  output logic        o_op_err
);

`ifdef MDIO_PREAMBLE_EN
  localparam state_e FIRST_STATE = S_PRE;
`else
  localparam state_e FIRST_STATE = S_HDR;
`endif

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_LEN - 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BITS - 1);
  localparam logic [CNT_W-1:0] TA_LAST   = CNT_W'(TA_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [31:0]            r_shift;
  logic [DATA_BITS-1:0]   r_rx;
  logic [DATA_BITS-1:0]   r_rd_data;
  logic                   r_is_read;
  logic                   r_ta_bad;
  logic                   r_ta_err;
  logic                   r_op_err;
  logic                   w_en;
  logic                   w_mdc;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_capture;
  logic                   w_op_err;
  op_class_t              w_cls;

  assign w_cls = classify(i_t_data[ST_LSB +: 2], i_t_data[OP_LSB +: 2]);
  assign w_en  = r_state inside {S_PRE, S_HDR, S_TA, S_DATA};

  mdio_clk_div #(.DIV(DIV)) u_clk_div (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_en       (w_en),
    .o_mdc      (w_mdc),
    .o_rise_stb (w_rise),
    .o_fall_stb (w_fall)
  );

  // NOTE: every signal written here is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_op_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_mdio_start) begin
          w_capture = 1'b1;
          if (w_cls.legal) w_state_nxt = FIRST_STATE;
          else             w_op_err    = 1'b1;
        end
      end
      S_PRE:   if (w_fall && r_bit_cnt == PRE_LAST)  w_state_nxt = S_HDR;
      S_HDR:   if (w_fall && r_bit_cnt == HDR_LAST)  w_state_nxt = S_TA;
      S_TA:    if (w_fall && r_bit_cnt == TA_LAST)   w_state_nxt = S_DATA;
      S_DATA:  if (w_fall && r_bit_cnt == DATA_LAST) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_rx      <= '0;
      r_rd_data <= '0;
      r_is_read <= 1'b0;
      r_ta_bad  <= 1'b0;
      r_ta_err  <= 1'b0;
      r_op_err  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_op_err <= w_op_err;

      if (w_state_nxt != r_state) r_bit_cnt <= '0;
      else if (w_fall)            r_bit_cnt <= r_bit_cnt + CNT_W'(1);

      if (w_capture) begin
        r_shift   <= i_t_data;
        r_is_read <= w_cls.read;
        r_ta_err  <= 1'b0;
      end else if (w_fall && (r_state inside {S_HDR, S_TA, S_DATA})) begin
        r_shift <= {r_shift[30:0], 1'b0};
      end

      // The PHY drives the second turnaround bit low when it answers a read.
      if (w_rise && r_state == S_TA && r_bit_cnt == TA_LAST) r_ta_bad <= i_mdio_in;
      if (w_rise && r_state == S_DATA) r_rx <= {r_rx[DATA_BITS-2:0], i_mdio_in};

      if (r_is_read && r_state == S_DATA && w_state_nxt == S_FIN) begin
        r_rd_data <= r_rx;
        r_ta_err  <= r_ta_bad;
      end
    end
  end

  always_comb begin
    o_mdio_out = 1'b0;
    o_mdio_oe  = 1'b0;
    case (r_state)
      S_PRE: begin
        o_mdio_out = 1'b1;
        o_mdio_oe  = 1'b1;
      end
      S_HDR: begin
        o_mdio_out = r_shift[31];
        o_mdio_oe  = 1'b1;
      end
      S_TA, S_DATA: begin
        o_mdio_out = r_shift[31];
        o_mdio_oe  = ~r_is_read;
      end
      default: begin
        o_mdio_out = 1'b0;
        o_mdio_oe  = 1'b0;
      end
    endcase
  end

  assign o_mdc      = w_mdc;
  assign o_busy     = w_en;
  assign o_done     = (r_state == S_FIN);
  assign o_data_rdy = (r_state == S_FIN) & r_is_read;
  assign o_rd_data  = r_rd_data;
  assign o_ta_err   = r_ta_err;
  assign o_op_err   = r_op_err;

endmodule

// File: tb/tb_mdio_xact_gen.sv
// Self-checking bench for mdio_xact_gen: a cycle-level frame model derived
// from bit timing arithmetic plus directed and randomized transactions.
module tb_mdio_xact_gen;

  localparam int DIV     = 2;
  localparam int PRE_LEN = 32;
`ifdef MDIO_PREAMBLE_EN
  localparam int P            = PRE_LEN;
  localparam int DONE_CYC_LIT = 257;
`else
  localparam int P            = 0;
  localparam int DONE_CYC_LIT = 129;
`endif
  localparam int NB        = P + 32;
  localparam int BIT_CYC   = 2 * DIV;
  localparam int FRAME_CYC = BIT_CYC * NB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] t_data = '0;
  logic        mdio_in = 1'b1;
  logic        mdc, mdio_out, mdio_oe, data_rdy, done, busy, ta_err, op_err;
  logic [15:0] rd_data;

  mdio_xact_gen #(.DIV(DIV), .PRE_LEN(PRE_LEN)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_mdio_start (start),
    .i_t_data     (t_data),
    .i_mdio_in    (mdio_in),
    .o_mdc        (mdc),
    .o_mdio_out   (mdio_out),
    .o_mdio_oe    (mdio_oe),
    .o_rd_data    (rd_data),
    .o_data_rdy   (data_rdy),
    .o_done       (done),
    .o_busy       (busy),
    .o_ta_err     (ta_err),
    .o_op_err     (op_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Protocol rules written directly from the ST/OP table.
  function automatic bit spec_legal(input logic [31:0] w);
    return (w[31:30] == 2'b01 && (w[29:28] == 2'b01 || w[29:28] == 2'b10)) || w[31:30] == 2'b00;
  endfunction

  function automatic bit spec_read(input logic [31:0] w);
    return (w[31:30] == 2'b01 && w[29:28] == 2'b10) || (w[31:30] == 2'b00 && w[29] == 1'b1);
  endfunction

  function automatic logic frame_bit(input logic [31:0] w, input int k);
    if (k < P) return 1'b1;
    return w[31 - (k - P)];
  endfunction

  // Reference model state, advanced by observing the DUT inputs.
  bit          chk_en = 1'b0;
  bit          m_active = 1'b0;
  int          m_start = 0;
  logic [31:0] m_word = '0;
  bit          m_read = 1'b0;
  logic [15:0] m_phy_word = '0;
  logic        m_phy_ta = 1'b0;
  logic [15:0] m_rd = '0;
  logic        m_ta_err = 1'b0;
  int          m_op_err_cyc = -1;

  logic [15:0] phy_word = '0;
  logic        phy_ta = 1'b0;

  int          rel_c, t_c, k_c;
  logic        e_mdc, e_out, e_oe, e_busy, e_done, e_rdy;
  logic [23:0] exp_v, act_v;

  always @(negedge clk) begin
    if (chk_en) begin
      e_mdc = 1'b0; e_out = 1'b0; e_oe = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b0;
      mdio_in = 1'b1;
      if (m_active) begin
        rel_c = cyc - m_start;
        if (rel_c >= 1 && rel_c <= FRAME_CYC) begin
          t_c    = rel_c - 1;
          k_c    = t_c / BIT_CYC;
          e_busy = 1'b1;
          e_mdc  = ((t_c % BIT_CYC) >= DIV);
          e_out  = frame_bit(m_word, k_c);
          e_oe   = !(m_read && k_c >= P + 14);
          if (m_read && k_c >= P + 14)
            mdio_in = (k_c < P + 16) ? m_phy_ta : m_phy_word[15 - (k_c - P - 16)];
        end else if (rel_c == FRAME_CYC + 1) begin
          e_done = 1'b1;
          e_rdy  = m_read;
          if (m_read) begin
            m_rd     = m_phy_word;
            m_ta_err = m_phy_ta;
          end
        end else begin
          m_active = 1'b0;
        end
      end
      exp_v = {e_mdc, e_out, e_oe, e_busy, e_done, e_rdy, m_ta_err, (cyc == m_op_err_cyc), m_rd};
      act_v = {mdc, mdio_out, mdio_oe, busy, done, data_rdy, ta_err, op_err, rd_data};
      check("cycle_outputs", 64'(act_v), 64'(exp_v));

      if (reset) begin
        m_active     = 1'b0;
        m_rd         = '0;
        m_ta_err     = 1'b0;
        m_op_err_cyc = -1;
      end else if (start && !m_active) begin
        m_ta_err = 1'b0;
        if (spec_legal(t_data)) begin
          m_active   = 1'b1;
          m_start    = cyc;
          m_word     = t_data;
          m_read     = spec_read(t_data);
          m_phy_word = phy_word;
          m_phy_ta   = phy_ta;
        end else begin
          m_op_err_cyc = cyc + 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [31:0] w, input logic [15:0] pw, input logic pt,
                             output int c0);
    phy_word = pw;
    phy_ta   = pt;
    t_data   = w;
    start    = 1'b1;
    c0       = cyc;
    tick();
    start  = 1'b0;
    t_data = $urandom;
  endtask

  task automatic wait_done(input int c0, output int rel);
    bit found;
    found = 1'b0;
    rel   = -1;
    for (int i = 0; i < FRAME_CYC + 40; i++) begin
      if (done) begin
        found = 1'b1;
        rel   = cyc - c0;
        break;
      end
      tick();
    end
    check("done_seen", 64'(found), 64'd1);
  endtask

  initial begin
    int c0, rel;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mdc_oe", 64'({mdc, mdio_oe, mdio_out}), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    tick();

    start_frame(32'h508ABEEF, 16'h0000, 1'b0, c0);
    wait_done(c0, rel);
    check("wr_done_cycle", 64'(rel), 64'(DONE_CYC_LIT));
    check("wr_data_rdy", 64'(data_rdy), 64'd0);
    tick();

    start_frame(32'h60880000, 16'h1234, 1'b0, c0);
    wait_done(c0, rel);
    check("rd_done_cycle", 64'(rel), 64'(DONE_CYC_LIT));
    check("rd_data_1234", 64'(rd_data), 64'h1234);
    check("rd_rdy_ta", 64'({data_rdy, ta_err}), 64'b10);
    tick();

    start_frame(32'h60880000, 16'hFFFF, 1'b1, c0);
    wait_done(c0, rel);
    check("rd_data_ffff", 64'(rd_data), 64'hFFFF);
    check("rd_ta_err", 64'(ta_err), 64'd1);
    repeat (3) tick();
    check("ta_err_held", 64'(ta_err), 64'd1);

    start_frame(32'h70000000, 16'h0000, 1'b0, c0);
    check("op_err_pulse", 64'({op_err, busy, mdc}), 64'b100);
    tick();
    check("op_err_clear", 64'({op_err, busy, mdc}), 64'b000);
    tick();

    start_frame(32'h30880000, 16'hA5A5, 1'b0, c0);
    while (cyc < c0 + 50) tick();
    t_data = 32'h508ABEEF;
    start  = 1'b1;
    tick();
    start = 1'b0;
    wait_done(c0, rel);
    check("c45_done_cycle", 64'(rel), 64'(DONE_CYC_LIT));
    check("c45_rd_data", 64'(rd_data), 64'hA5A5);
    repeat (2) tick();
    check("no_restart", 64'(busy), 64'd0);

    start_frame(32'h508ABEEF, 16'h0000, 1'b0, c0);
    while (cyc < c0 + 100) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_abort", 64'({mdc, mdio_out, mdio_oe, data_rdy, done, busy, ta_err, op_err, rd_data}), 64'd0);
    repeat (20) tick();
    start_frame(32'h508ABEEF, 16'h0000, 1'b0, c0);
    wait_done(c0, rel);
    check("post_rst_done", 64'(rel), 64'(DONE_CYC_LIT));
    tick();

    for (int it = 0; it < 40; it++) begin
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 7))
        0:       w[31:28] = 4'b0101;
        1:       w[31:28] = 4'b0110;
        2:       w[31:28] = 4'b0000;
        3:       w[31:28] = 4'b0001;
        4:       w[31:28] = 4'b0011;
        5:       w[31:28] = 4'b0010;
        default: w[31:28] = 4'($urandom);
      endcase
      repeat ($urandom_range(0, 3)) tick();
      start_frame(w, 16'($urandom), ($urandom_range(0, 7) == 0), c0);
      if (!spec_legal(w)) begin
        tick();
        continue;
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 60)) tick();
        t_data = $urandom;
        start  = 1'b1;
        tick();
        start = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 60)) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        wait_done(c0, rel);
        tick();
      end
    end

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
